// File: rtl/picotb_pkg.sv
// Shared types and constants for the PicoSoC UART banner checker.
package picotb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam logic [7:0] PRINT_LO = 8'd32;
  localparam logic [7:0] PRINT_HI = 8'd127;

  // True for bytes that take part in banner matching.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b < PRINT_HI);
  endfunction

endpackage

// File: rtl/picotb_uart_rx.sv
// 8N1 UART receiver: input synchroniser plus a start/data/stop sampling FSM.
module picotb_uart_rx #(
  parameter int unsigned HALF_PERIOD = 53
) (
  input  logic       clk,
  input  logic       tb_rst,
  input  logic       enable,
  input  logic       ser_tx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  import picotb_pkg::*;

  localparam int unsigned CNT_W = $clog2(2 * HALF_PERIOD);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(2 * HALF_PERIOD - 1);

  logic [1:0]       sync_q;
  logic             sync_d;
  logic             rx;
  logic             rx_fall;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  assign rx      = sync_q[1];
  assign rx_fall = !sync_q[1] && sync_d;

  // Two-flop synchroniser on the asynchronous line, plus one delay for edge detect.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      sync_q <= 2'b11;
      sync_d <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], ser_tx};
      sync_d <= sync_q[1];
    end
  end

  // Receive FSM: one down-counter times the start-bit centre and every following bit centre.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rx_fall) begin
              state <= START;
              cnt   <= HALF_RELOAD;
            end
          end
          START: begin
            if (cnt == '0) begin
              if (rx) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                cnt     <= BIT_RELOAD;
                bit_idx <= '0;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DATA: begin
            if (cnt == '0) begin
              shift   <= {rx, shift[7:1]};
              cnt     <= BIT_RELOAD;
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) begin
                state <= STOP;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          STOP: begin
            if (cnt == '0) begin
              if (rx) begin
                byte_valid <= 1'b1;
                byte_data  <= shift;
              end else begin
                frame_err <= 1'b1;
              end
              state <= IDLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/picotb_uart_checker.sv
// Boot-banner checker: receives SoC UART output and issues sticky pass/fail verdicts.
module picotb_uart_checker #(
  parameter int unsigned          HALF_PERIOD    = 53,
  parameter int unsigned          EXP_LEN        = 34,
  parameter logic [EXP_LEN*8-1:0] EXP_STR        = "Booting..Press ENTER to continue..",
  parameter int unsigned          TIMEOUT_CYCLES = 300000
) (
  input  logic                           clk,
  input  logic                           tb_rst,
  input  logic                           enable,
  input  logic                           ser_tx,
  output logic                           byte_valid,
  output logic [7:0]                     byte_data,
  output logic                           frame_err,
  output logic [$clog2(EXP_LEN+1)-1:0]   match_cnt,
  output logic                           pass,
  output logic                           fail
);
  import picotb_pkg::*;

  localparam int unsigned MC_W  = $clog2(EXP_LEN + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [7:0]       exp_byte;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_sat;
  logic             tmo_hit;
  logic             match_last;

  picotb_uart_rx #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_rx (
    .clk       (clk),
    .tb_rst    (tb_rst),
    .enable    (enable),
    .ser_tx    (ser_tx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  // Select the next expected character; first character sits in the MSBs.
  always_comb begin
    exp_byte = '0;
    for (int unsigned i = 0; i < EXP_LEN; i++) begin
      if (match_cnt == MC_W'(i)) begin
        exp_byte = EXP_STR[(EXP_LEN-1-i)*8 +: 8];
      end
    end
  end

  assign tmo_sat    = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
  assign tmo_hit    = (tmo_cnt >= TMO_W'(TIMEOUT_CYCLES - 1));
  assign match_last = (match_cnt == MC_W'(EXP_LEN - 1));

  // Matcher, saturating timeout and sticky verdicts; frozen while disabled.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      match_cnt <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      tmo_cnt   <= '0;
    end else if (enable) begin
      if (!tmo_sat) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (frame_err) begin
        pass <= 1'b0;
        fail <= 1'b1;
      end else if (byte_valid && is_printable(byte_data)) begin
        if (pass) begin
          pass <= 1'b0;
          fail <= 1'b1;
        end else if (!fail) begin
          if (byte_data == exp_byte) begin
            match_cnt <= match_cnt + 1'b1;
            if (match_last) begin
              pass <= 1'b1;
            end
          end else begin
            fail <= 1'b1;
          end
        end
      end
      // A timeout overrides a pass that would only land in this same cycle.
      if (tmo_hit && !pass) begin
        pass <= 1'b0;
        fail <= 1'b1;
      end
    end
  end

endmodule
